// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer
// Multi-cycle control sequencer for a single-ALU RISC datapath. An instruction
// class is latched on acceptance. Every control output is then decoded from
// the current state and the latched class. Memory accesses are guarded by a
// 255-cycle wait timeout. Completed instructions are counted in retireCount.
module alu_share_sequencer (
    input  logic        clk,
    input  logic        resetN,
    input  logic        instrValid,
    input  logic [2:0]  instrClass,
    input  logic        branchTaken,
    input  logic        memReady,
    output logic        instrReady,
    output logic        selectOperandA,
    output logic        selectOperandB,
    output logic        selectConstFour,
    output logic        regWrite,
    output logic        pcWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        done,
    output logic        illegal,
    output logic        memFault,
    output logic [31:0] retireCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_TGT   = 3'd3,
        S_PCUPD = 3'd4
    } state_t;

    localparam logic [2:0] C_ALUR   = 3'd0;
    localparam logic [2:0] C_ALUI   = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_JAL    = 3'd5;
    localparam logic [2:0] C_JALR   = 3'd6;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_class;
    logic [7:0]  r_wait;
    logic [31:0] r_retire;
    logic        w_is_load;
    logic        w_is_store;

    assign w_is_load   = (r_class == C_LOAD);
    assign w_is_store  = (r_class == C_STORE);
    assign retireCount = r_retire;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the instruction class only when an instruction is accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_class <= 3'd0;
        end else if (r_state == S_IDLE && instrValid) begin
            r_class <= instrClass;
        end
    end

    // Memory wait counter: reads as zero on MEM entry, counts stalled MEM cycles.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wait <= 8'd0;
        end else if (r_state != S_MEM) begin
            r_wait <= 8'd0;
        end else if (!memReady) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Retire counter: one count per done cycle, wrapping naturally.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_retire <= 32'd0;
        end else if (done) begin
            r_retire <= r_retire + 32'd1;
        end
    end

    // Next-state and control decode from (state, latched class).
    always_comb begin
        w_next_state    = r_state;
        instrReady      = 1'b0;
        selectOperandA  = 1'b0;
        selectOperandB  = 1'b0;
        selectConstFour = 1'b0;
        regWrite        = 1'b0;
        pcWrite         = 1'b0;
        memRead         = 1'b0;
        memWrite        = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;
        memFault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so nothing is advertised while held in reset.
                instrReady = resetN;
                if (instrValid) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_ALUR: begin
                        regWrite     = 1'b1;
                        w_next_state = S_PCUPD;
                    end
                    C_ALUI: begin
                        selectOperandB = 1'b1;
                        regWrite       = 1'b1;
                        w_next_state   = S_PCUPD;
                    end
                    C_LOAD, C_STORE: begin
                        selectOperandB = 1'b1;
                        w_next_state   = S_MEM;
                    end
                    C_BRANCH: begin
                        selectOperandA = 1'b1;
                        selectOperandB = 1'b1;
                        if (branchTaken) begin
                            pcWrite      = 1'b1;
                            done         = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_PCUPD;
                        end
                    end
                    C_JAL, C_JALR: begin
                        selectOperandA  = 1'b1;
                        selectConstFour = 1'b1;
                        regWrite        = 1'b1;
                        w_next_state    = S_TGT;
                    end
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = S_PCUPD;
                    end
                endcase
            end
            S_MEM: begin
                if (memReady) begin
                    // Completion wins even in the timeout cycle.
                    memRead      = w_is_load;
                    memWrite     = w_is_store;
                    regWrite     = w_is_load;
                    w_next_state = S_PCUPD;
                end else if (r_wait == 8'd255) begin
                    memFault     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    memRead  = w_is_load;
                    memWrite = w_is_store;
                end
            end
            S_TGT: begin
                selectOperandA = (r_class == C_JAL);
                selectOperandB = 1'b1;
                pcWrite        = 1'b1;
                done           = 1'b1;
                w_next_state   = S_IDLE;
            end
            S_PCUPD: begin
                selectOperandA  = 1'b1;
                selectConstFour = 1'b1;
                pcWrite         = 1'b1;
                done            = 1'b1;
                w_next_state    = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Testbench for alu_share_sequencer: scenario tasks checked cycle by cycle
// against an instruction-level reference that lists, per class, the
// expected control word of every cycle from acceptance to completion.
module tb_alu_share_sequencer;

    logic        clk;
    logic        resetN;
    logic        instrValid;
    logic [2:0]  instrClass;
    logic        branchTaken;
    logic        memReady;
    logic        instrReady;
    logic        selectOperandA;
    logic        selectOperandB;
    logic        selectConstFour;
    logic        regWrite;
    logic        pcWrite;
    logic        memRead;
    logic        memWrite;
    logic        done;
    logic        illegal;
    logic        memFault;
    logic [31:0] retireCount;

    alu_share_sequencer dut (
        .clk             (clk),
        .resetN          (resetN),
        .instrValid      (instrValid),
        .instrClass      (instrClass),
        .branchTaken     (branchTaken),
        .memReady        (memReady),
        .instrReady      (instrReady),
        .selectOperandA  (selectOperandA),
        .selectOperandB  (selectOperandB),
        .selectConstFour (selectConstFour),
        .regWrite        (regWrite),
        .pcWrite         (pcWrite),
        .memRead         (memRead),
        .memWrite        (memWrite),
        .done            (done),
        .illegal         (illegal),
        .memFault        (memFault),
        .retireCount     (retireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word bit positions.
    localparam logic [10:0] B_RDY  = 11'h400;
    localparam logic [10:0] B_OPA  = 11'h200;
    localparam logic [10:0] B_OPB  = 11'h100;
    localparam logic [10:0] B_C4   = 11'h080;
    localparam logic [10:0] B_RW   = 11'h040;
    localparam logic [10:0] B_PCW  = 11'h020;
    localparam logic [10:0] B_MR   = 11'h010;
    localparam logic [10:0] B_MW   = 11'h008;
    localparam logic [10:0] B_DONE = 11'h004;
    localparam logic [10:0] B_ILL  = 11'h002;
    localparam logic [10:0] B_FLT  = 11'h001;
    localparam logic [10:0] W_PCUPD = B_OPA | B_C4 | B_PCW | B_DONE;

    int          n_checks;
    int          n_fail;
    logic [31:0] model_retire;
    logic [10:0] exp_q[$];
    bit          mr_q[$];
    bit          exp_retires;

    function automatic logic [10:0] obs_vec();
        return {instrReady, selectOperandA, selectOperandB, selectConstFour, regWrite,
                pcWrite, memRead, memWrite, done, illegal, memFault};
    endfunction

    // Instruction-level reference: control word and memReady drive per cycle.
    // waits >= 256 means memReady never arrives (timeout).
    task automatic build_expect(input logic [2:0] cls, input bit taken, input int waits);
        logic [10:0] memb;
        exp_q.delete();
        mr_q.delete();
        exp_retires = 1'b1;
        case (cls)
            3'd0: begin exp_q.push_back(B_RW);         mr_q.push_back(1'($urandom));
                        exp_q.push_back(W_PCUPD);      mr_q.push_back(1'($urandom)); end
            3'd1: begin exp_q.push_back(B_OPB | B_RW); mr_q.push_back(1'($urandom));
                        exp_q.push_back(W_PCUPD);      mr_q.push_back(1'($urandom)); end
            3'd2, 3'd3: begin
                memb = (cls == 3'd2) ? B_MR : B_MW;
                exp_q.push_back(B_OPB); mr_q.push_back(1'($urandom));
                if (waits >= 256) begin
                    for (int k = 0; k < 255; k++) begin exp_q.push_back(memb); mr_q.push_back(1'b0); end
                    exp_q.push_back(B_FLT); mr_q.push_back(1'b0);
                    exp_retires = 1'b0;
                end else begin
                    for (int k = 0; k < waits; k++) begin exp_q.push_back(memb); mr_q.push_back(1'b0); end
                    exp_q.push_back(memb | ((cls == 3'd2) ? B_RW : 11'h000)); mr_q.push_back(1'b1);
                    exp_q.push_back(W_PCUPD); mr_q.push_back(1'($urandom));
                end
            end
            3'd4: begin
                if (taken) begin
                    exp_q.push_back(B_OPA | B_OPB | B_PCW | B_DONE); mr_q.push_back(1'($urandom));
                end else begin
                    exp_q.push_back(B_OPA | B_OPB); mr_q.push_back(1'($urandom));
                    exp_q.push_back(W_PCUPD);       mr_q.push_back(1'($urandom));
                end
            end
            3'd5, 3'd6: begin
                exp_q.push_back(B_OPA | B_C4 | B_RW); mr_q.push_back(1'($urandom));
                exp_q.push_back(B_OPB | B_PCW | B_DONE | ((cls == 3'd5) ? B_OPA : 11'h000));
                mr_q.push_back(1'($urandom));
            end
            default: begin
                exp_q.push_back(B_ILL);   mr_q.push_back(1'($urandom));
                exp_q.push_back(W_PCUPD); mr_q.push_back(1'($urandom));
            end
        endcase
    endtask

    // Accept one instruction and compare every cycle until it finishes.
    // Busy cycles carry random instrValid/instrClass to show no re-acceptance.
    task automatic run_instr(input logic [2:0] cls, input bit taken, input int waits, input string name);
        logic [10:0] obs;
        @(negedge clk);
        instrValid  = 1'b1;
        instrClass  = cls;
        memReady    = 1'($urandom);
        branchTaken = 1'($urandom);
        #1;
        n_checks++;
        if (instrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_ready: got %b want 1", name, instrReady);
        end
        @(posedge clk);
        build_expect(cls, taken, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            instrValid  = 1'($urandom);
            instrClass  = 3'($urandom);
            memReady    = mr_q[i];
            branchTaken = (i == 0 && cls == 3'd4) ? taken : 1'($urandom);
            #1;
            obs = obs_vec();
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle%0d: got %03h want %03h", name, i, obs, exp_q[i]);
            end
        end
        if (exp_retires) model_retire = model_retire + 32'd1;
        @(negedge clk);
        instrValid = 1'b0;
        #1;
        obs = obs_vec();
        n_checks++;
        if (obs !== B_RDY || retireCount !== model_retire) begin
            n_fail++;
            $display("FAIL %s idle_after: ctrl %03h retire %08h want ctrl %03h retire %08h",
                     name, obs, retireCount, B_RDY, model_retire);
        end
        $display("txn %s class=%0d taken=%0d waits=%0d retire=%08h", name, cls, taken, waits, retireCount);
    endtask

    task automatic test_reset();
        resetN = 1'b0; instrValid = 1'b1; instrClass = 3'd0; branchTaken = 1'b0; memReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== 11'h000 || retireCount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl %03h retire %08h want 000 00000000", obs_vec(), retireCount);
        end
        @(negedge clk);
        instrValid = 1'b0;
        resetN = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== B_RDY) begin
            n_fail++;
            $display("FAIL reset_release_ready: ctrl %03h want %03h", obs_vec(), B_RDY);
        end
        model_retire = 32'd0;
        $display("txn reset ctrl=%03h retire=%08h", obs_vec(), retireCount);
    endtask

    task automatic test_alu();
        run_instr(3'd0, 1'b0, 0, "alu_r");
        run_instr(3'd1, 1'b0, 0, "alu_i");
    endtask

    task automatic test_load_wait();
        run_instr(3'd2, 1'b0, 3, "load_wait3");
        run_instr(3'd3, 1'b0, 0, "store_nowait");
    endtask

    task automatic test_branch();
        run_instr(3'd4, 1'b1, 0, "branch_taken");
        run_instr(3'd4, 1'b0, 0, "branch_not_taken");
    endtask

    task automatic test_store_timeout();
        run_instr(3'd3, 1'b0, 256, "store_timeout");
        run_instr(3'd3, 1'b0, 255, "store_ready_at_255");
        run_instr(3'd2, 1'b0, 254, "load_ready_at_254");
    endtask

    task automatic test_jalr_illegal();
        run_instr(3'd6, 1'b0, 0, "jalr");
        run_instr(3'd7, 1'b0, 0, "illegal");
        run_instr(3'd5, 1'b0, 0, "jal");
    endtask

    task automatic test_random();
        logic [2:0] cls;
        for (int n = 0; n < 40; n++) begin
            cls = 3'($urandom);
            run_instr(cls, 1'($urandom), int'($urandom_range(0, 6)), "random");
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_retire = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire;
        model_retire = 32'hFFFF_FFFF;
        n_checks++;
        if (retireCount !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %08h want ffffffff", retireCount);
        end
        run_instr(3'd1, 1'b0, 0, "alu_i_wrap");
        n_checks++;
        if (retireCount !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %08h want 00000000", retireCount);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        instrValid = 1'b1; instrClass = 3'd2; memReady = 1'b0;
        @(posedge clk);
        @(negedge clk);                 // EXEC
        instrValid = 1'b0;
        @(negedge clk);                 // MEM, stalled
        memReady = 1'b0;
        @(negedge clk);                 // MEM, completion offered together with reset
        memReady = 1'b1;
        resetN = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 11'h000 || retireCount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_in_mem: ctrl %03h retire %08h want 000 00000000", obs_vec(), retireCount);
        end
        @(negedge clk);
        resetN = 1'b1;
        memReady = 1'b0;
        #1;
        model_retire = 32'd0;
        n_checks++;
        if (obs_vec() !== B_RDY || retireCount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_in_mem_recover: ctrl %03h retire %08h want %03h 00000000",
                     obs_vec(), retireCount, B_RDY);
        end
        $display("txn reset_mid ctrl=%03h retire=%08h", obs_vec(), retireCount);
        run_instr(3'd0, 1'b0, 0, "alu_r_after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        model_retire = 32'd0;
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_store_timeout();
        test_jalr_illegal();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_sequencer.md
ALU_SHARE_SEQUENCER -- requirements
Module: alu_share_sequencer

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide port: resetN  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide port: instrValid  input  1  decoded instruction present.
REQ-004 SHALL provide port: instrClass  input  3  0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal.
REQ-005 SHALL provide port: branchTaken  input  1  comparator result, sampled in EXEC of BRANCH only.
REQ-006 SHALL provide port: memReady  input  1  data-memory completion.
REQ-007 SHALL provide port: instrReady  output  1  accept; transfer when instrValid&instrReady at a rising edge.
REQ-008 SHALL provide ports: selectOperandA  output  1  (0 rs1, 1 pc); selectOperandB  output  1  (0 rs2, 1 immediate); selectConstFour  output  1  (1 overrides operand B with 32'd4).
REQ-009 SHALL provide ports: regWrite, pcWrite, memRead, memWrite, done, illegal, memFault  output  1 each.
REQ-010 SHALL provide port: retireCount  output  32  completed-instruction counter.

Function
REQ-011 SHALL implement states IDLE, EXEC, MEM, TGT, PCUPD; class latched on acceptance.
REQ-012 SHALL drive instrReady=1 only in IDLE; acceptance moves IDLE->EXEC; no acceptance in any other state.
REQ-013 SHALL drive all control outputs as decode of (state, latched class); every unlisted output 0.
REQ-014 ALU-R EXEC: opA=0, opB=0, regWrite=1; ALU-I EXEC: opA=0, opB=1, regWrite=1; both -> PCUPD.
REQ-015 LOAD/STORE EXEC: opA=0, opB=1 (address); -> MEM.
REQ-016 MEM: memRead=1 (LOAD) or memWrite=1 (STORE) held every cycle until memReady; in memReady cycle LOAD also regWrite=1; -> PCUPD.
REQ-017 BRANCH EXEC: opA=1, opB=1; branchTaken=1 -> pcWrite=1, done=1, -> IDLE; branchTaken=0 -> PCUPD.
REQ-018 JAL/JALR EXEC: opA=1, selectConstFour=1, regWrite=1 (link); -> TGT.
REQ-019 TGT: opB=1, pcWrite=1, done=1; opA=1 for JAL, opA=0 for JALR; -> IDLE.
REQ-020 PCUPD: opA=1, selectConstFour=1, pcWrite=1, done=1; -> IDLE.
REQ-021 Class 7: EXEC asserts illegal=1 for one cycle, no regWrite; -> PCUPD.
REQ-022 Latency accept-edge to done: ALU 2 cycles, branch taken 1, branch not-taken 2, JAL/JALR 2, LOAD/STORE 3+wait.
REQ-023 SHALL keep an 8-bit wait counter cleared on MEM entry, incremented each MEM cycle with memReady=0.
REQ-024 If counter reaches 255 with memReady=0: memFault=1 one cycle, memRead/memWrite drop, no regWrite, no pcWrite, no done; -> IDLE.
REQ-025 memReady=1 in the timeout cycle SHALL win: normal completion, no memFault.
REQ-026 memReady outside MEM SHALL be ignored; branchTaken outside BRANCH EXEC ignored.
REQ-027 retireCount SHALL increment by 1 on every cycle with done=1, wrap 0xFFFFFFFF->0; memFault does not retire; illegal does retire.
REQ-028 Datapath latches rs1/rs2/imm/pc on acceptance; sequencer assumes no operand change mid-instruction.

Reset
REQ-029 resetN=0 SHALL asynchronously force IDLE, class 0, wait counter 0, retireCount 0, all outputs 0 incl. instrReady.
REQ-030 After resetN rises, instrReady=1 from first cycle; reset mid-instruction SHALL abandon it with no done, pcWrite or retire.

Verification
REQ-031 ALU-R accepted at edge 0 -> EXEC cycle regWrite=1, opA=0, opB=0; next cycle pcWrite=1, constFour=1, done=1; retireCount=1; instrReady=1 following cycle.
REQ-032 LOAD, memReady low 3 cycles then high -> memRead=1 for 4 cycles, regWrite only in 4th, then PCUPD done; retireCount+1.
REQ-033 BRANCH taken=1 -> single EXEC cycle with pcWrite=1, done=1, opA=1, opB=1; taken=0 -> extra PCUPD cycle.
REQ-034 STORE, memReady never -> memWrite held 255 cycles, memFault pulse, return IDLE, retireCount unchanged; repeat with memReady on cycle 255 -> no memFault.
REQ-035 JALR then illegal: JALR EXEC link regWrite, TGT opA=0 pcWrite; illegal pulse without regWrite, then PCUPD done.
REQ-036 Preload retireCount 0xFFFFFFFF via 2^32 retires (or forced), one more ALU-I -> 0; resetN low in MEM -> all outputs 0 immediately, no done.
